// File: rtl/signed_bcd_converter.sv
// Iterative binary-to-BCD converter (double-dabble) with sign handling.
// Accepts one word at a time over valid/ready and returns sign + packed BCD magnitude.
module signed_bcd_converter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_neg,
  output logic [4*DIGITS-1:0]   out_bcd
);

  // True when DIGITS decimal digits can represent every value up to 2^WIDTH.
  function automatic bit digits_fit();
    logic [127:0] p;
    logic [127:0] lim;
    p   = 128'd1;
    lim = 128'd1 << WIDTH;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (p <= lim) p = p * 128'd10;
    end
    return p > lim;
  endfunction

  localparam bit Fits = digits_fit();

  if (WIDTH < 2 || !Fits) begin : g_param_check
    $error("signed_bcd_converter: need WIDTH >= 2 and 10^DIGITS > 2^WIDTH");
  end

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StAbs, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic                  sgn_q, sgn_d;
  logic                  neg_q, neg_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   res_bcd_q, res_bcd_d;
  logic                  res_neg_q, res_neg_d;

  logic [4*DIGITS-1:0]   bcd_adj;
  logic [4*DIGITS-1:0]   bcd_shift;
  logic [WIDTH-1:0]      mag_shift;

  // Add 3 to every digit >= 5 so the following shift carries correctly into the next digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[4*DIGITS-2:0], mag_q[WIDTH-1]};
    mag_shift = {mag_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    sgn_d     = sgn_q;
    neg_d     = neg_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    res_bcd_d = res_bcd_q;
    res_neg_d = res_neg_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mag_d   = in_data;
          sgn_d   = in_signed;
          state_d = StAbs;
        end
      end
      StAbs: begin
        neg_d   = sgn_q & mag_q[WIDTH-1];
        mag_d   = neg_d ? (~mag_q + 1'b1) : mag_q;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        bcd_d = bcd_shift;
        mag_d = mag_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_bcd_d = bcd_shift;
          // A zero magnitude is never reported as negative.
          res_neg_d = neg_q & (|bcd_shift);
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mag_q     <= '0;
      sgn_q     <= 1'b0;
      neg_q     <= 1'b0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      res_bcd_q <= '0;
      res_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      sgn_q     <= sgn_d;
      neg_q     <= neg_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      res_bcd_q <= res_bcd_d;
      res_neg_q <= res_neg_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_neg   = res_neg_q;
  assign out_bcd   = res_bcd_q;

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Randomised bench for signed_bcd_converter: directed 16-bit vectors, backpressure,
// mid-conversion reset, and an exhaustive 8-bit sweep against an arithmetic model.
module tb_signed_bcd_converter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid16 = 1'b0, in_signed16 = 1'b0, out_ready16 = 1'b0;
  logic [15:0] in_data16 = '0;
  logic        in_ready16, out_valid16, out_neg16;
  logic [19:0] out_bcd16;

  logic        in_valid8 = 1'b0, in_signed8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0]  in_data8 = '0;
  logic        in_ready8, out_valid8, out_neg8;
  logic [11:0] out_bcd8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signed_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in_data   (in_data16),
    .in_signed (in_signed16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out_neg   (out_neg16),
    .out_bcd   (out_bcd16)
  );

  signed_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .in_signed (in_signed8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_neg   (out_neg8),
    .out_bcd   (out_bcd8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decimal digits of |value| computed with plain integer arithmetic.
  function automatic void model(input int unsigned w, input logic [31:0] d, input bit s,
                                output bit neg, output logic [31:0] bcd);
    longint unsigned v, m;
    v   = 64'(d) & ((64'd1 << w) - 64'd1);
    neg = s && (((v >> (w - 1)) & 64'd1) == 64'd1);
    m   = neg ? ((64'd1 << w) - v) : v;
    neg = neg && (m != 0);
    bcd = '0;
    for (int k = 0; k < 8; k++) begin
      bcd = bcd | (32'(m % 10) << (4 * k));
      m   = m / 10;
    end
  endfunction

  task automatic conv16(input logic [15:0] d, input bit s, input int stall,
                        input bit exp_neg, input logic [19:0] exp_bcd);
    int k;
    @(negedge clk);
    check("idle_ready", 32'(in_ready16), 32'd1);
    in_valid16  = 1'b1;
    in_data16   = d;
    in_signed16 = s;
    @(negedge clk);
    in_valid16 = 1'b0;
    k = 0;
    while (!out_valid16 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'd17);
    check("neg", 32'(out_neg16), 32'(exp_neg));
    check("bcd", 32'(out_bcd16), 32'(exp_bcd));
    repeat (stall) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid16), 32'd1);
      check("hold_bcd", 32'(out_bcd16), 32'(exp_bcd));
      check("hold_busy", 32'(in_ready16), 32'd0);
    end
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
    check("valid_drop", 32'(out_valid16), 32'd0);
    check("ready_back", 32'(in_ready16), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          mn;
    logic [31:0] mb;
    logic [15:0] r;
    int          k;
    bit          done;

    #12;
    check("rst_ready", 32'(in_ready16), 32'd1);
    check("rst_valid", 32'(out_valid16), 32'd0);
    check("rst_neg", 32'(out_neg16), 32'd0);
    check("rst_bcd", 32'(out_bcd16), 32'd0);
    check("rst_valid8", 32'(out_valid8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    conv16(16'hF8EB, 1'b1, 0, 1'b1, 20'h01813);
    conv16(16'h8000, 1'b1, 0, 1'b1, 20'h32768);
    conv16(16'h8000, 1'b0, 0, 1'b0, 20'h32768);
    conv16(16'hFFFF, 1'b0, 0, 1'b0, 20'h65535);
    conv16(16'hFFFF, 1'b1, 0, 1'b1, 20'h00001);
    conv16(16'h0000, 1'b1, 0, 1'b0, 20'h00000);
    conv16(16'h1234, 1'b0, 6, 1'b0, 20'h04660);

    // Abort a conversion 5 cycles after acceptance.
    @(negedge clk);
    in_valid16  = 1'b1;
    in_data16   = 16'h0001;
    in_signed16 = 1'b0;
    @(negedge clk);
    in_valid16 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid16), 32'd0);
    check("abort_bcd", 32'(out_bcd16), 32'd0);
    check("abort_ready", 32'(in_ready16), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    conv16(16'h7FFF, 1'b1, 0, 1'b0, 20'h32767);

    for (int i = 0; i < 8; i++) begin
      r = 16'($urandom);
      model(16, 32'(r), i[0], mn, mb);
      conv16(r, i[0], $urandom_range(0, 3), mn, mb[19:0]);
    end

    // Exhaustive 8-bit sweep with random stalls and stray in_valid pulses while busy.
    for (int i = 0; i < 256; i++) begin
      for (int s = 0; s < 2; s++) begin
        model(8, 32'(i), s[0], mn, mb);
        @(negedge clk);
        check("sw_ready", 32'(in_ready8), 32'd1);
        in_valid8  = 1'b1;
        in_data8   = i[7:0];
        in_signed8 = s[0];
        @(negedge clk);
        done = 1'b0;
        k = 0;
        while (!done && k < 100) begin
          in_valid8  = 1'($urandom_range(0, 1));
          in_data8   = 8'($urandom);
          in_signed8 = 1'($urandom_range(0, 1));
          out_ready8 = 1'($urandom_range(0, 1));
          if (out_valid8 && out_ready8) begin
            check("sw_neg", 32'(out_neg8), 32'(mn));
            check("sw_bcd", 32'(out_bcd8), 32'(mb[11:0]));
            in_valid8 = 1'b0;
            done = 1'b1;
          end
          @(negedge clk);
          k++;
        end
        out_ready8 = 1'b0;
        in_valid8  = 1'b0;
        check("sw_done", 32'(done), 32'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
